bcd_conversor_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter for the board's 7-segment output path. It replaces the combinational, fixed 4-digit conversion with an iterative double-dabble engine that processes one bit per clock. It adds a start/done handshake, a configurable digit count, an optional signed mode, and overflow saturation. Output digits are registered and held until the next completed conversion, so the segment decoders always see a stable value.

---
 rtl/bcd_conversor_seq.sv | 129 ++++++++++++
 tb/tb_bcd_conversor_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conversor_seq.sv
// rtl/bcd_conversor_seq.sv - iterative double-dabble binary-to-BCD converter with start/done handshake
module bcd_conversor_seq #(
  parameter int LARGURA = 16,
  parameter int DIGITOS = 5,
  parameter int SINAL   = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [LARGURA-1:0]     entrada,
  input  logic                   escrever,
  output logic                   ocupado,
  output logic                   pronto,
  output logic [4*DIGITOS-1:0]   digitos,
  output logic                   negativo,
  output logic                   estouro
);

  localparam int BW = 4 * DIGITOS;
  localparam int CW = $clog2(LARGURA + 1);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } estado_t;

  estado_t              state_q, state_d;
  logic [LARGURA-1:0]   mag_q, mag_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 sign_q, sign_d;
  logic [BW-1:0]        digitos_q, digitos_d;
  logic                 negativo_q, negativo_d;
  logic                 estouro_q, estouro_d;
  logic                 pronto_q, pronto_d;
  logic [BW-1:0]        adj;
  logic                 neg_in;

  // Next-state, datapath iteration and result publication
  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    sign_d     = sign_q;
    digitos_d  = digitos_q;
    negativo_d = negativo_q;
    estouro_d  = estouro_q;
    pronto_d   = 1'b0;
    neg_in     = (SINAL != 0) && entrada[LARGURA-1];

    // Add-3 correction on every digit, no carry between nibbles
    adj = bcd_q;
    for (int i = 0; i < DIGITOS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    case (state_q)
      OCIOSO: begin
        if (escrever) begin
          sign_d  = neg_in;
          mag_d   = neg_in ? (~entrada + 1'b1) : entrada;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CW'(LARGURA);
          state_d = CONVERTE;
        end
      end
      CONVERTE: begin
        // A set bit leaving the top digit means the value no longer fits
        bcd_d = {adj[BW-2:0], mag_q[LARGURA-1]};
        mag_d = {mag_q[LARGURA-2:0], 1'b0};
        ovf_d = ovf_q | adj[BW-1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIM;
        end
      end
      FIM: begin
        digitos_d  = ovf_q ? {DIGITOS{4'h9}} : bcd_q;
        estouro_d  = ovf_q;
        negativo_d = sign_q;
        pronto_d   = 1'b1;
        state_d    = OCIOSO;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  // State and datapath registers; reset discards any conversion in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= OCIOSO;
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      sign_q     <= 1'b0;
      digitos_q  <= '0;
      negativo_q <= 1'b0;
      estouro_q  <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      sign_q     <= sign_d;
      digitos_q  <= digitos_d;
      negativo_q <= negativo_d;
      estouro_q  <= estouro_d;
      pronto_q   <= pronto_d;
    end
  end

  assign ocupado  = (state_q != OCIOSO);
  assign pronto   = pronto_q;
  assign digitos  = digitos_q;
  assign negativo = negativo_q;
  assign estouro  = estouro_q;

endmodule

// File: tb/tb_bcd_conversor_seq.sv
// tb/tb_bcd_conversor_seq.sv - directed-vector bench for bcd_conversor_seq in four configurations
module tb_bcd_conversor_seq;

  logic        clock;
  logic        reset;
  logic        go;
  logic [1:0]  sel;
  logic [15:0] ent;

  int vectors;
  int miscompares;

  logic        ocup0, ocup1, ocup2, ocup3;
  logic        pr0, pr1, pr2, pr3;
  logic        neg0, neg1, neg2, neg3;
  logic        est0, est1, est2, est3;
  logic [19:0] dig0;
  logic [15:0] dig1;
  logic [19:0] dig2;
  logic [11:0] dig3;

  logic        ocup_m, pronto_m, neg_m, est_m;
  logic [19:0] dig_m;

  bcd_conversor_seq #(.LARGURA(16), .DIGITOS(5), .SINAL(0)) u0 (
    .clock(clock), .reset(reset), .entrada(ent), .escrever(go && sel == 2'd0),
    .ocupado(ocup0), .pronto(pr0), .digitos(dig0), .negativo(neg0), .estouro(est0));

  bcd_conversor_seq #(.LARGURA(16), .DIGITOS(4), .SINAL(0)) u1 (
    .clock(clock), .reset(reset), .entrada(ent), .escrever(go && sel == 2'd1),
    .ocupado(ocup1), .pronto(pr1), .digitos(dig1), .negativo(neg1), .estouro(est1));

  bcd_conversor_seq #(.LARGURA(16), .DIGITOS(5), .SINAL(1)) u2 (
    .clock(clock), .reset(reset), .entrada(ent), .escrever(go && sel == 2'd2),
    .ocupado(ocup2), .pronto(pr2), .digitos(dig2), .negativo(neg2), .estouro(est2));

  bcd_conversor_seq #(.LARGURA(8), .DIGITOS(3), .SINAL(0)) u3 (
    .clock(clock), .reset(reset), .entrada(ent[7:0]), .escrever(go && sel == 2'd3),
    .ocupado(ocup3), .pronto(pr3), .digitos(dig3), .negativo(neg3), .estouro(est3));

  always_comb begin
    ocup_m = ocup0; pronto_m = pr0; neg_m = neg0; est_m = est0; dig_m = dig0;
    case (sel)
      2'd1: begin ocup_m = ocup1; pronto_m = pr1; neg_m = neg1; est_m = est1; dig_m = {4'h0, dig1}; end
      2'd2: begin ocup_m = ocup2; pronto_m = pr2; neg_m = neg2; est_m = est2; dig_m = dig2; end
      2'd3: begin ocup_m = ocup3; pronto_m = pr3; neg_m = neg3; est_m = est3; dig_m = {8'h0, dig3}; end
      default: ;
    endcase
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One conversion on the selected instance; returns at the pronto sample (or -1 on timeout)
  task automatic convert(input logic [1:0] s, input logic [15:0] v, output int lat, output int busy);
    sel = s; ent = v; go = 1'b1;
    @(posedge clock); #1;
    go = 1'b0;
    lat = -1; busy = 0;
    for (int k = 1; k <= 40; k++) begin
      if (ocup_m) busy++;
      @(posedge clock); #1;
      if (pronto_m) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); #1;
      vectors++;
      if (dig_m !== 20'h0 || ocup_m !== 1'b0 || pronto_m !== 1'b0 || est_m !== 1'b0 || neg_m !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state inst%0d: dig=%h ocup=%b pronto=%b est=%b neg=%b, required all 0", s, dig_m, ocup_m, pronto_m, est_m, neg_m);
      end
    end
  endtask

  task automatic test_unsigned_max();
    int lat, busy;
    convert(2'd0, 16'hFFFF, lat, busy);
    vectors++;
    if (lat !== 17) begin miscompares++; $display("FAIL max_latency: got %0d, required 17", lat); end
    vectors++;
    if (busy !== 17) begin miscompares++; $display("FAIL max_busy_cycles: got %0d, required 17", busy); end
    vectors++;
    if (dig_m !== 20'h65535 || est_m !== 1'b0 || neg_m !== 1'b0) begin
      miscompares++; $display("FAIL max_result: dig=%h est=%b neg=%b, required 65535/0/0", dig_m, est_m, neg_m);
    end
    @(posedge clock); #1;
    vectors++;
    if (pronto_m !== 1'b0 || ocup_m !== 1'b0 || dig_m !== 20'h65535) begin
      miscompares++; $display("FAIL max_hold: pronto=%b ocup=%b dig=%h, required 0/0/65535", pronto_m, ocup_m, dig_m);
    end
  endtask

  task automatic test_overflow();
    int lat, busy;
    logic [15:0] vin [3] = '{16'h270F, 16'h2710, 16'h0000};
    logic [19:0] vdig [3] = '{20'h09999, 20'h09999, 20'h00000};
    logic        vest [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      convert(2'd1, vin[i], lat, busy);
      vectors++;
      if (lat !== 17 || dig_m !== vdig[i] || est_m !== vest[i] || neg_m !== 1'b0) begin
        miscompares++;
        $display("FAIL overflow_%h: lat=%0d dig=%h est=%b neg=%b, required 17/%h/%b/0", vin[i], lat, dig_m, est_m, neg_m, vdig[i], vest[i]);
      end
    end
  endtask

  task automatic test_signed();
    int lat, busy;
    logic [15:0] vin [3] = '{16'h8000, 16'hFFFF, 16'h7FFF};
    logic [19:0] vdig [3] = '{20'h32768, 20'h00001, 20'h32767};
    logic        vneg [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      convert(2'd2, vin[i], lat, busy);
      vectors++;
      if (lat !== 17 || dig_m !== vdig[i] || neg_m !== vneg[i] || est_m !== 1'b0) begin
        miscompares++;
        $display("FAIL signed_%h: lat=%0d dig=%h neg=%b est=%b, required 17/%h/%b/0", vin[i], lat, dig_m, neg_m, est_m, vdig[i], vneg[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int npr, first, t [8];
    sel = 2'd0; ent = 16'h1234; go = 1'b1;
    @(posedge clock); #1;
    go = 1'b0; ent = 16'h0001;
    npr = 0; first = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (pronto_m) begin
        npr++;
        if (first < 0) begin
          first = k;
          vectors++;
          if (dig_m !== 20'h04660) begin miscompares++; $display("FAIL ignore_result: dig=%h, required 04660", dig_m); end
        end
      end
      go = (k == 4 || k == 16);
    end
    vectors++;
    if (npr !== 1 || first !== 17) begin
      miscompares++; $display("FAIL ignore_single_pronto: count=%0d at=%0d, required 1 at 17", npr, first);
    end
    vectors++;
    if (ocup_m !== 1'b0 || dig_m !== 20'h04660) begin
      miscompares++; $display("FAIL ignore_no_restart: ocup=%b dig=%h, required 0/04660", ocup_m, dig_m);
    end
    ent = 16'h0099; go = 1'b1; npr = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clock); #1;
      if (pronto_m && npr < 8) begin t[npr] = k; npr++; end
    end
    go = 1'b0;
    vectors++;
    if (npr !== 4 || t[0] !== 18) begin
      miscompares++; $display("FAIL hold_pulse_count: count=%0d first=%0d, required 4 first 18", npr, t[0]);
    end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (t[i] - t[i-1] !== 18) begin
        miscompares++; $display("FAIL hold_interval_%0d: got %0d, required 18", i, t[i] - t[i-1]);
      end
    end
    vectors++;
    if (dig_m !== 20'h00153) begin miscompares++; $display("FAIL hold_result: dig=%h, required 00153", dig_m); end
    repeat (20) @(posedge clock);
    #1;
  endtask

  task automatic test_reset_abort();
    int lat, busy, npr;
    convert(2'd0, 16'h0042, lat, busy);
    vectors++;
    if (lat !== 17 || dig_m !== 20'h00066) begin
      miscompares++; $display("FAIL abort_pre: lat=%0d dig=%h, required 17/00066", lat, dig_m);
    end
    ent = 16'hFFFF; go = 1'b1;
    @(posedge clock); #1;
    go = 1'b0;
    repeat (7) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    vectors++;
    if (dig_m !== 20'h0 || ocup_m !== 1'b0 || pronto_m !== 1'b0 || est_m !== 1'b0 || neg_m !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state: dig=%h ocup=%b pronto=%b est=%b neg=%b, required all 0", dig_m, ocup_m, pronto_m, est_m, neg_m);
    end
    npr = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clock); #1;
      if (pronto_m || ocup_m) npr++;
    end
    vectors++;
    if (npr !== 0) begin miscompares++; $display("FAIL abort_no_pronto: active cycles=%0d, required 0", npr); end
    convert(2'd0, 16'h00FF, lat, busy);
    vectors++;
    if (lat !== 17 || dig_m !== 20'h00255 || est_m !== 1'b0) begin
      miscompares++; $display("FAIL abort_after: lat=%0d dig=%h est=%b, required 17/00255/0", lat, dig_m, est_m);
    end
  endtask

  task automatic test_sweep8();
    int lat, busy;
    logic [19:0] expv;
    for (int v = 0; v < 256; v++) begin
      convert(2'd3, 16'(v), lat, busy);
      expv = {8'h0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      vectors++;
      if (lat !== 9 || dig_m !== expv || est_m !== 1'b0 || neg_m !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep8_%0d: lat=%0d dig=%h est=%b neg=%b, required 9/%h/0/0", v, lat, dig_m, est_m, neg_m, expv);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; go = 1'b0; sel = 2'd0; ent = 16'h0;
    test_reset();
    test_unsigned_max();
    test_overflow();
    test_signed();
    test_back_to_back();
    test_reset_abort();
    test_sweep8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
